// File: rtl/w0rm_core_writeback.sv
// Writeback stage: merges ALU and load results onto the single register file write port,
// buffers colliding results, and tracks pending writes so decode can stall on hazards.
module w0rm_core_writeback #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 16,
   parameter int REG_ADDR_BITS = 4,
   parameter int BUF_DEPTH     = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     alu_result_valid,
   input  logic [REG_ADDR_BITS-1:0] alu_result_addr,
   input  logic [DATA_WIDTH-1:0]    alu_result_data,
   output logic                     alu_result_ready,
   input  logic                     mem_result_valid,
   input  logic [REG_ADDR_BITS-1:0] mem_result_addr,
   input  logic [DATA_WIDTH-1:0]    mem_result_data,
   input  logic                     issue_valid,
   input  logic [REG_ADDR_BITS-1:0] issue_addr,
   input  logic [REG_ADDR_BITS-1:0] check_read0_addr,
   input  logic [REG_ADDR_BITS-1:0] check_read1_addr,
   input  logic [REG_ADDR_BITS-1:0] check_dest_addr,
   output logic                     hazard_stall,
   output logic [REG_ADDR_BITS-1:0] port_write_addr,
   output logic                     port_write_enable,
   output logic [DATA_WIDTH-1:0]    port_write_data
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [CNT_W-1:0]         count;
   logic [CNT_W-1:0]         nxt_count;
   logic [REG_ADDR_BITS-1:0] buf_addr     [BUF_DEPTH];
   logic [DATA_WIDTH-1:0]    buf_data     [BUF_DEPTH];
   logic [REG_ADDR_BITS-1:0] nxt_buf_addr [BUF_DEPTH];
   logic [DATA_WIDTH-1:0]    nxt_buf_data [BUF_DEPTH];
   logic [NUM_REGISTERS-1:0] busy;
   logic [NUM_REGISTERS-1:0] nxt_busy;

   logic                     cand_valid [4];
   logic [REG_ADDR_BITS-1:0] cand_addr  [4];
   logic [DATA_WIDTH-1:0]    cand_data  [4];
   logic                     commit_valid;
   logic [REG_ADDR_BITS-1:0] commit_addr;
   logic [DATA_WIDTH-1:0]    commit_data;
   logic [2:0]               n_cand;
   logic                     stall0, stall1, stall2;

   // Handshake: an ALU result transfers on a cycle where alu_result_valid && alu_result_ready;
   // a load result transfers whenever mem_result_valid, so ALU is refused only when a load
   // arrives while the buffer is already full.
   assign alu_result_ready = !mem_result_valid || (count < CNT_W'(BUF_DEPTH));

   // Candidates in priority order: oldest buffered, next buffered, load, ALU.
   always_comb begin
      cand_valid[0] = (count >= CNT_W'(1));
      cand_addr[0]  = buf_addr[0];
      cand_data[0]  = buf_data[0];
      cand_valid[1] = (count >= CNT_W'(2));
      cand_addr[1]  = buf_addr[1];
      cand_data[1]  = buf_data[1];
      cand_valid[2] = mem_result_valid;
      cand_addr[2]  = mem_result_addr;
      cand_data[2]  = mem_result_data;
      cand_valid[3] = alu_result_valid && alu_result_ready;
      cand_addr[3]  = alu_result_addr;
      cand_data[3]  = alu_result_data;
   end

   // First valid candidate takes the port; the rest compact into the buffer in order.
   always_comb begin
      commit_valid = 1'b0;
      commit_addr  = '0;
      commit_data  = '0;
      nxt_buf_addr = buf_addr;
      nxt_buf_data = buf_data;
      n_cand       = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (cand_valid[i]) begin
            if (n_cand == 3'd0) begin
               commit_valid = 1'b1;
               commit_addr  = cand_addr[i];
               commit_data  = cand_data[i];
            end else if (n_cand == 3'd1) begin
               nxt_buf_addr[0] = cand_addr[i];
               nxt_buf_data[0] = cand_data[i];
            end else if (n_cand == 3'd2) begin
               nxt_buf_addr[1] = cand_addr[i];
               nxt_buf_data[1] = cand_data[i];
            end
            n_cand = n_cand + 3'd1;
         end
      end
      nxt_count = (n_cand == 3'd0) ? '0 : CNT_W'(n_cand - 3'd1);
   end

   // Issue after clear so a same-cycle set wins.
   always_comb begin
      nxt_busy = busy;
      if (port_write_enable) nxt_busy[port_write_addr] = 1'b0;
      if (issue_valid)       nxt_busy[issue_addr]      = 1'b1;
   end

   // A write on the port this cycle lands before the registered read, so it does not stall.
   assign stall0 = busy[check_read0_addr] &&
                   !(port_write_enable && (check_read0_addr == port_write_addr));
   assign stall1 = busy[check_read1_addr] &&
                   !(port_write_enable && (check_read1_addr == port_write_addr));
   assign stall2 = busy[check_dest_addr] &&
                   !(port_write_enable && (check_dest_addr == port_write_addr));
   assign hazard_stall = stall0 || stall1 || stall2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         port_write_enable <= 1'b0;
         port_write_addr   <= '0;
         port_write_data   <= '0;
         count             <= '0;
         busy              <= '0;
         buf_addr          <= '{default: '0};
         buf_data          <= '{default: '0};
      end else if (flush) begin
         port_write_enable <= 1'b0;
         count             <= '0;
         busy              <= '0;
      end else begin
         port_write_enable <= commit_valid;
         if (commit_valid) begin
            port_write_addr <= commit_addr;
            port_write_data <= commit_data;
         end
         count    <= nxt_count;
         buf_addr <= nxt_buf_addr;
         buf_data <= nxt_buf_data;
         busy     <= nxt_busy;
      end
   end

endmodule
